// File: rtl/ex_pkg.sv
// Shared encodings for the RV32IM execute stage: ALU opcodes, divider states,
// forwarding selects and control-bit positions.
package ex_pkg;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_AND    = 5'd2,
      ALU_OR     = 5'd3,
      ALU_XOR    = 5'd4,
      ALU_SLL    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_SLT    = 5'd8,
      ALU_SLTU   = 5'd9,
      ALU_PASSB  = 5'd10,
      ALU_MUL    = 5'd11,
      ALU_MULH   = 5'd12,
      ALU_MULHSU = 5'd13,
      ALU_MULHU  = 5'd14,
      ALU_DIV    = 5'd15,
      ALU_DIVU   = 5'd16,
      ALU_REM    = 5'd17,
      ALU_REMU   = 5'd18
   } alu_op_e;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_ALU = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam int CTRL_MEMREAD  = 4;
   localparam int CTRL_MEMWRITE = 3;
   localparam int CTRL_ALUSRC   = 5;

   function automatic logic is_div_op(input logic [4:0] op);
      return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
   endfunction

   function automatic logic is_signed_div_op(input logic [4:0] op);
      return (op == ALU_DIV) || (op == ALU_REM);
   endfunction

   function automatic logic is_rem_op(input logic [4:0] op);
      return (op == ALU_REM) || (op == ALU_REMU);
   endfunction

endpackage

// File: rtl/ex_divider.sv
// Iterative radix-2 restoring divider with sign fix-up; divide-by-zero and
// signed overflow bypass the iterations and finish in one cycle.
module ex_divider
   import ex_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int DIV_ITERS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            signed_op,
   input  logic            rem_op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(DIV_ITERS);

   div_state_e state, next_state;

   logic [CNT_W-1:0] count;
   logic [XLEN-1:0]  quot;
   logic [XLEN-1:0]  rem;
   logic [XLEN-1:0]  divisor;
   logic             neg_q;
   logic             neg_r;
   logic             rem_sel;

   logic            a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, overflow, special;
   logic [XLEN:0]   trial;
   logic            trial_ok;
   logic [XLEN-1:0] q_fix, r_fix;

   assign a_neg    = signed_op & a[XLEN-1];
   assign b_neg    = signed_op & b[XLEN-1];
   assign a_mag    = a_neg ? (~a + 1'b1) : a;
   assign b_mag    = b_neg ? (~b + 1'b1) : b;
   assign div_zero = (b == '0);
   assign overflow = signed_op && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
   assign special  = div_zero | overflow;

   // Shifted partial remainder minus divisor; a clear MSB means the subtract fits.
   assign trial    = {rem, quot[XLEN-1]} - {1'b0, divisor};
   assign trial_ok = ~trial[XLEN];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= DIV_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         DIV_IDLE: if (start) next_state = special ? DIV_DONE : DIV_BUSY;
         DIV_BUSY: if (count == CNT_W'(DIV_ITERS - 1)) next_state = DIV_DONE;
         DIV_DONE: next_state = DIV_IDLE;
         default:  next_state = DIV_IDLE;
      endcase
   end

   // Special cases preload the final quotient/remainder with sign fix-up disabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count   <= '0;
         quot    <= '0;
         rem     <= '0;
         divisor <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         rem_sel <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  count   <= '0;
                  rem_sel <= rem_op;
                  divisor <= b_mag;
                  if (div_zero) begin
                     quot  <= '1;
                     rem   <= a;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                  end else if (overflow) begin
                     quot  <= {1'b1, {(XLEN-1){1'b0}}};
                     rem   <= '0;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                  end else begin
                     quot  <= a_mag;
                     rem   <= '0;
                     neg_q <= a_neg ^ b_neg;
                     neg_r <= a_neg;
                  end
               end
            end
            DIV_BUSY: begin
               count <= count + 1'b1;
               rem   <= trial_ok ? trial[XLEN-1:0] : {rem[XLEN-2:0], quot[XLEN-1]};
               quot  <= {quot[XLEN-2:0], trial_ok};
            end
            default: ;
         endcase
      end
   end

   assign q_fix  = neg_q ? (~quot + 1'b1) : quot;
   assign r_fix  = neg_r ? (~rem + 1'b1) : rem;
   assign result = rem_sel ? r_fix : q_fix;
   assign busy   = (state == DIV_BUSY);
   assign done   = (state == DIV_DONE);

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: operand forwarding, ALU, single-cycle multiplier,
// iterative divider with front-end stall, and the EX/MEM pipeline register.
module ex_stage
   import ex_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int DIV_ITERS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_ex,
   input  logic [5:0]      ctrl_ex,
   input  logic [4:0]      alu_op,
   input  logic [XLEN-1:0] pc4_ex,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rd_ex,
   input  logic [1:0]      fwd_a,
   input  logic [1:0]      fwd_b,
   input  logic [XLEN-1:0] wb_data,
   output logic            stall,
   output logic [4:0]      ctrl_mem,
   output logic [XLEN-1:0] rd_mem,
   output logic [XLEN-1:0] pc4_mem,
   output logic [XLEN-1:0] alu_result,
   output logic [XLEN-1:0] write_data1
);

   logic [XLEN-1:0]   op_a, rs2_fwd, op_b;
   logic [XLEN-1:0]   alu_out, ex_result;
   logic [2*XLEN-1:0] mul_a, mul_b, product;
   logic              div_start, div_busy, div_done;
   logic [XLEN-1:0]   div_result;

   // The reserved select 11 falls through to the register-file value.
   always_comb begin
      op_a = rs1_data;
      case (fwd_a)
         FWD_ALU: op_a = alu_result;
         FWD_WB:  op_a = wb_data;
         default: op_a = rs1_data;
      endcase
      rs2_fwd = rs2_data;
      case (fwd_b)
         FWD_ALU: rs2_fwd = alu_result;
         FWD_WB:  rs2_fwd = wb_data;
         default: rs2_fwd = rs2_data;
      endcase
   end

   assign op_b = ctrl_ex[CTRL_ALUSRC] ? imm : rs2_fwd;

   // Operands are extended to 2*XLEN so one multiplier serves all four variants.
   always_comb begin
      mul_a = {{XLEN{1'b0}}, op_a};
      mul_b = {{XLEN{1'b0}}, op_b};
      if ((alu_op == ALU_MULH) || (alu_op == ALU_MULHSU)) mul_a = {{XLEN{op_a[XLEN-1]}}, op_a};
      if (alu_op == ALU_MULH) mul_b = {{XLEN{op_b[XLEN-1]}}, op_b};
   end

   assign product = mul_a * mul_b;

   always_comb begin
      alu_out = '0;
      case (alu_op)
         ALU_ADD:    alu_out = op_a + op_b;
         ALU_SUB:    alu_out = op_a - op_b;
         ALU_AND:    alu_out = op_a & op_b;
         ALU_OR:     alu_out = op_a | op_b;
         ALU_XOR:    alu_out = op_a ^ op_b;
         ALU_SLL:    alu_out = op_a << op_b[4:0];
         ALU_SRL:    alu_out = op_a >> op_b[4:0];
         ALU_SRA:    alu_out = $signed(op_a) >>> op_b[4:0];
         ALU_SLT:    alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_SLTU:   alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         ALU_PASSB:  alu_out = op_b;
         ALU_MUL:    alu_out = product[XLEN-1:0];
         ALU_MULH,
         ALU_MULHSU,
         ALU_MULHU:  alu_out = product[2*XLEN-1:XLEN];
         default:    alu_out = '0;
      endcase
   end

   // The divide stays in ID/EX through DONE, so issue is blocked there to avoid a replay.
   assign div_start = valid_ex && is_div_op(alu_op) && !div_busy && !div_done && !reset;
   assign stall     = div_start | div_busy;

   ex_divider #(
      .XLEN      (XLEN),
      .DIV_ITERS (DIV_ITERS)
   ) u_divider (
      .clk       (clk),
      .reset     (reset),
      .start     (div_start),
      .signed_op (is_signed_div_op(alu_op)),
      .rem_op    (is_rem_op(alu_op)),
      .a         (op_a),
      .b         (op_b),
      .busy      (div_busy),
      .done      (div_done),
      .result    (div_result)
   );

   assign ex_result = is_div_op(alu_op) ? div_result : alu_out;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_mem    <= '0;
         rd_mem      <= '0;
         pc4_mem     <= '0;
         alu_result  <= '0;
         write_data1 <= '0;
      end else if (stall || !valid_ex) begin
         ctrl_mem    <= '0;
         rd_mem      <= '0;
         pc4_mem     <= '0;
         alu_result  <= '0;
         write_data1 <= '0;
      end else begin
         ctrl_mem    <= ctrl_ex[4:0];
         rd_mem      <= rd_ex;
         pc4_mem     <= pc4_ex;
         alu_result  <= ex_result;
         write_data1 <= rs2_fwd;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: forwarding, ALU/multiply results,
// divider latency and special cases, and asynchronous reset mid-division.
module tb_ex_stage;
   import ex_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_ex;
   logic [5:0]  ctrl_ex;
   logic [4:0]  alu_op;
   logic [31:0] pc4_ex, rs1_data, rs2_data, imm, rd_ex, wb_data;
   logic [1:0]  fwd_a, fwd_b;
   logic        stall;
   logic [4:0]  ctrl_mem;
   logic [31:0] rd_mem, pc4_mem, alu_result, write_data1;

   int total_checks  = 0;
   int passed_checks = 0;

   ex_stage #(.XLEN(32), .DIV_ITERS(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .valid_ex    (valid_ex),
      .ctrl_ex     (ctrl_ex),
      .alu_op      (alu_op),
      .pc4_ex      (pc4_ex),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .imm         (imm),
      .rd_ex       (rd_ex),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b),
      .wb_data     (wb_data),
      .stall       (stall),
      .ctrl_mem    (ctrl_mem),
      .rd_mem      (rd_mem),
      .pc4_mem     (pc4_mem),
      .alu_result  (alu_result),
      .write_data1 (write_data1)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total_checks++;
      assert (observed === expected) passed_checks++;
      else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic [4:0] op, input logic [5:0] ctrl,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                                input logic [1:0] fa, input logic [1:0] fb);
      valid_ex = 1'b1;
      alu_op   = op;
      ctrl_ex  = ctrl;
      rs1_data = a;
      rs2_data = b;
      imm      = im;
      fwd_a    = fa;
      fwd_b    = fb;
      pc4_ex   = 32'h0000_1004;
      rd_ex    = 32'd5;
   endtask

   task automatic runDivide(input string tag, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
      int  cnt;
      logic bubble_ok;
      applyStimulus(op, 6'b000000, a, b, 32'h0, FWD_REG, FWD_REG);
      #1;
      cnt       = 0;
      bubble_ok = 1'b1;
      while (stall === 1'b1 && cnt < 40) begin
         cnt++;
         @(negedge clk);
         if (alu_result !== 32'h0 || ctrl_mem !== 5'h0 || rd_mem !== 32'h0 ||
             pc4_mem !== 32'h0 || write_data1 !== 32'h0) bubble_ok = 1'b0;
      end
      checkOutput({tag, " stall cycles"}, 32'(cnt), 32'(exp_stall));
      checkOutput({tag, " bubble"}, {31'b0, bubble_ok}, 32'h1);
      @(negedge clk);
      checkOutput({tag, " result"}, alu_result, exp_res);
      valid_ex = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      valid_ex = 1'b0;
      ctrl_ex  = '0;
      alu_op   = '0;
      pc4_ex   = '0;
      rs1_data = '0;
      rs2_data = '0;
      imm      = '0;
      rd_ex    = '0;
      fwd_a    = '0;
      fwd_b    = '0;
      wb_data  = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset stall", {31'b0, stall}, 32'h0);
      checkOutput("reset alu_result", alu_result, 32'h0);
      checkOutput("reset ctrl_mem", {27'b0, ctrl_mem}, 32'h0);
      reset = 1'b0;

      applyStimulus(ALU_ADD, 6'b100000, 32'h10, 32'h0, 32'h0, FWD_REG, FWD_REG);
      #1 checkOutput("add stall", {31'b0, stall}, 32'h0);
      @(negedge clk);
      checkOutput("add result", alu_result, 32'h10);
      checkOutput("add pc4", pc4_mem, 32'h1004);
      checkOutput("add rd", rd_mem, 32'd5);

      applyStimulus(ALU_ADD, 6'b100000, 32'h5, 32'h0, 32'h3, FWD_ALU, FWD_REG);
      @(negedge clk);
      checkOutput("fwd alu", alu_result, 32'h13);

      wb_data = 32'h50;
      applyStimulus(ALU_SUB, 6'b000000, 32'h20, 32'h8, 32'h0, FWD_WB, FWD_REG);
      @(negedge clk);
      checkOutput("fwd wb sub", alu_result, 32'h48);

      applyStimulus(ALU_XOR, 6'b000000, 32'hFF, 32'h0, 32'h0, FWD_REG, FWD_ALU);
      @(negedge clk);
      checkOutput("fwd_b alu xor", alu_result, 32'hB7);
      checkOutput("fwd_b write_data1", write_data1, 32'h48);

      wb_data = 32'h99;
      applyStimulus(ALU_ADD, 6'b100000, 32'h1, 32'h0, 32'h1, 2'b11, FWD_REG);
      @(negedge clk);
      checkOutput("fwd reserved", alu_result, 32'h2);

      applyStimulus(ALU_ADD, 6'b101000, 32'h100, 32'hDEADBEEF, 32'h4, FWD_REG, FWD_REG);
      @(negedge clk);
      checkOutput("store ctrl", {27'b0, ctrl_mem}, 32'h08);
      checkOutput("store data", write_data1, 32'hDEADBEEF);
      checkOutput("store addr", alu_result, 32'h104);

      applyStimulus(ALU_SRA, 6'b100000, 32'h80000000, 32'h0, 32'h4, FWD_REG, FWD_REG);
      @(negedge clk);
      checkOutput("sra", alu_result, 32'hF8000000);

      applyStimulus(ALU_SLL, 6'b000000, 32'h3, 32'h21, 32'h0, FWD_REG, FWD_REG);
      @(negedge clk);
      checkOutput("sll shamt5", alu_result, 32'h6);

      applyStimulus(ALU_SLT, 6'b000000, 32'hFFFFFFFF, 32'h1, 32'h0, FWD_REG, FWD_REG);
      @(negedge clk);
      checkOutput("slt", alu_result, 32'h1);

      applyStimulus(ALU_SLTU, 6'b000000, 32'hFFFFFFFF, 32'h1, 32'h0, FWD_REG, FWD_REG);
      @(negedge clk);
      checkOutput("sltu", alu_result, 32'h0);

      applyStimulus(ALU_PASSB, 6'b100000, 32'h77, 32'h0, 32'h12345000, FWD_REG, FWD_REG);
      @(negedge clk);
      checkOutput("lui", alu_result, 32'h12345000);

      applyStimulus(ALU_MUL, 6'b000000, 32'h7, 32'hFFFFFFFD, 32'h0, FWD_REG, FWD_REG);
      @(negedge clk);
      checkOutput("mul", alu_result, 32'hFFFFFFEB);

      applyStimulus(ALU_MULH, 6'b000000, 32'h80000000, 32'h80000000, 32'h0, FWD_REG, FWD_REG);
      @(negedge clk);
      checkOutput("mulh", alu_result, 32'h40000000);

      applyStimulus(ALU_MULHU, 6'b000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, FWD_REG, FWD_REG);
      @(negedge clk);
      checkOutput("mulhu", alu_result, 32'hFFFFFFFE);

      applyStimulus(ALU_MULHSU, 6'b000000, 32'hFFFFFFFF, 32'h2, 32'h0, FWD_REG, FWD_REG);
      @(negedge clk);
      checkOutput("mulhsu", alu_result, 32'hFFFFFFFF);

      valid_ex = 1'b0;
      @(negedge clk);
      checkOutput("bubble result", alu_result, 32'h0);
      checkOutput("bubble pc4", pc4_mem, 32'h0);

      runDivide("div -7/2", ALU_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33);
      runDivide("rem -7/2", ALU_REM, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33);
      runDivide("divu 100/7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33);
      runDivide("divu 9/0", ALU_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 1);
      runDivide("remu 9/0", ALU_REMU, 32'd9, 32'd0, 32'd9, 1);
      runDivide("div ovf", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

      applyStimulus(ALU_DIVU, 6'b000000, 32'd100, 32'd7, 32'h0, FWD_REG, FWD_REG);
      #1 checkOutput("mid-div issue stall", {31'b0, stall}, 32'h1);
      repeat (11) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("mid-div reset stall", {31'b0, stall}, 32'h0);
      checkOutput("mid-div reset result", alu_result, 32'h0);
      checkOutput("mid-div reset ctrl", {27'b0, ctrl_mem}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(ALU_ADD, 6'b100000, 32'h1, 32'h0, 32'h1, FWD_REG, FWD_REG);
      #1 checkOutput("post-reset stall", {31'b0, stall}, 32'h0);
      @(negedge clk);
      checkOutput("post-reset add", alu_result, 32'h2);
      valid_ex = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
